fa_vector_checker: RTL and testbench
====================================

Name: fa_vector_checker

Overview:
- Hardware-side counterpart to the full-adder stimulus sequence. It drives every {A,B,C} input combination into an external N-bit adder under test (DUT).
- It waits a programmable settle time after each vector, samples the DUT's sum and carry-out, and compares them against the expected value.
- It counts mismatches, captures the first failure, and reports DONE/PASS.
- It sits beside the adder in the lab experiment top level, so the adder can be self-tested on the board without a simulator.

Parameters:
- N, 1, operand width of the adder under test (1 = single full adder).
- SETTLE, 2, cycles each vector is held before sampling; legal range ≥1.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle request to begin an exhaustive run.
- A  out  N  operand A to DUT.
- B  out  N  operand B to DUT.
- C  out  1  carry-in to DUT.
- S  in  N  DUT sum.
- CO  in  1  DUT carry-out.
- BUSY  out  1  run in progress.
- DONE  out  1  run complete; level output.
- PASS  out  1  DONE && ERR_CNT==0.
- ERR_CNT  out  2N+2  number of mismatching vectors in the last run.
- FAIL_VEC  out  2N+1  {A,B,C} of the first mismatching vector.
- FAIL_GOT  out  N+1  {CO,S} observed at the first mismatch.

Behaviour:
- Reset, asynchronous on RST_N=0:
  - State goes to IDLE.
  - A, B, C, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC and FAIL_GOT all go to 0.
  - Reset asserted mid-run aborts immediately; no partial result is retained.
- Vector index v has width 2N+1. {A,B,C} = v, with C as the LSB. Order is ascending from 0 to 2^(2N+1)-1.
- Expected result: {CO,S}_exp = A + B + C, computed at N+1 bits, unsigned.
- FSM states: IDLE, DRIVE, CHECK, FINISH.
- IDLE:
  - A, B and C are held at 0.
  - START=1 at a clock edge: v←0, ERR_CNT←0, FAIL_VEC←0, FAIL_GOT←0, settle counter←0, BUSY←1, DONE←0, go to DRIVE.
- DRIVE:
  - {A,B,C}=v is registered and stable for the whole state.
  - The settle counter increments each cycle.
  - After SETTLE cycles in DRIVE, go to CHECK.
- CHECK (exactly 1 cycle):
  - Sample S and CO, and compare against {CO,S}_exp for v.
  - On mismatch: ERR_CNT←ERR_CNT+1. If this is the first mismatch (ERR_CNT==0 before the increment), FAIL_VEC←v and FAIL_GOT←{CO,S}.
  - If v is the last vector: go to FINISH, BUSY←0, DONE←1.
  - Otherwise: v←v+1, clear the settle counter, go to DRIVE.
  - A, B and C do not change during CHECK.
- FINISH:
  - DONE=1, BUSY=0.
  - A, B and C hold the last vector.
  - Results are held until START or reset.
  - START=1 begins a new run with the same actions as from IDLE.
- Timing:
  - Each vector takes SETTLE+1 cycles.
  - A run takes 2^(2N+1)·(SETTLE+1) cycles from the first DRIVE cycle to DONE rising.
- Boundary conditions:
  - START while BUSY is ignored and does not restart the run.
  - ERR_CNT is never incremented past 2^(2N+1), so no wrap is possible at width 2N+2.
  - FAIL_VEC and FAIL_GOT are 0 when no mismatch occurred. Distinguish this case using ERR_CNT, not the capture fields.
  - v reaching all-ones ends the run; v never wraps to 0 within a run.
  - PASS is combinational from DONE and ERR_CNT and is 0 whenever DONE=0.
  - DUT inputs S and CO are sampled only in CHECK. Glitches during DRIVE have no effect.

Test Plan:
- Correct-FA model (N=1, SETTLE=2), one START pulse:
  - A/B/C step through 000…111, each held 3 cycles.
  - DONE rises 24 cycles after the first DRIVE cycle; BUSY is high for those 24 cycles.
  - PASS=1, ERR_CNT=0.
- DUT with CO stuck at 0 (N=1):
  - ERR_CNT=4 (vectors 011, 101, 110, 111).
  - FAIL_VEC=3'b011, FAIL_GOT=2'b00, PASS=0.
- START re-pulsed at cycle 5 of a run:
  - Ignored; the run completes normally at cycle 24 with an unchanged result.
  - A second START in FINISH clears DONE and ERR_CNT next cycle and reruns.
- RST_N pulsed low while v=4:
  - All outputs read 0 immediately, without a clock edge.
  - The state is IDLE.
  - A following START gives a full clean 24-cycle run.
- N=4, SETTLE=1, DUT with S[0] inverted:
  - All 512 vectors mismatch, so ERR_CNT=512.
  - FAIL_VEC=0, FAIL_GOT=5'b00001.
  - DONE is reached after 1024 cycles.

Source files
------------

// File: rtl/fa_vector_checker.sv
// Exhaustive self-test driver for an N-bit adder.
// Steps {A,B,C} through all values, checks {CO,S}.
module fa_vector_checker #(
    parameter int N      = 1,
    parameter int SETTLE = 2
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           START,
    output logic [N-1:0]   A,
    output logic [N-1:0]   B,
    output logic           C,
    input  logic [N-1:0]   S,
    input  logic           CO,
    output logic           BUSY,
    output logic           DONE,
    output logic           PASS,
    output logic [2*N+1:0] ERR_CNT,
    output logic [2*N:0]   FAIL_VEC,
    output logic [N:0]     FAIL_GOT
);

    localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK,
        FINISH
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [2*N:0]    vec_q;
    logic [CW-1:0]   cnt_q;
    logic            start_run;
    logic            last_vec;
    logic            mismatch;
    logic [N:0]      exp_sum;
    logic [N:0]      got_sum;

    // The vector register drives the adder directly; it is 0 in IDLE.
    assign {A, B, C} = vec_q;

    assign exp_sum  = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, C};
    assign got_sum  = {CO, S};
    assign mismatch = (got_sum != exp_sum);
    assign last_vec = &vec_q;
    assign PASS     = DONE && (ERR_CNT == '0);

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and run-start strobe.
    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    start_run = 1'b1;
                    state_d   = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == SET_LAST) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = last_vec ? FINISH : DRIVE;
            end
            FINISH: begin
                if (START) begin
                    start_run = 1'b1;
                    state_d   = DRIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Vector, settle counter, status and first-failure capture.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vec_q    <= '0;
            cnt_q    <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR_CNT  <= '0;
            FAIL_VEC <= '0;
            FAIL_GOT <= '0;
        end else if (start_run) begin
            vec_q    <= '0;
            cnt_q    <= '0;
            BUSY     <= 1'b1;
            DONE     <= 1'b0;
            ERR_CNT  <= '0;
            FAIL_VEC <= '0;
            FAIL_GOT <= '0;
        end else if (state_q == DRIVE) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (state_q == CHECK) begin
            if (mismatch) begin
                ERR_CNT <= ERR_CNT + 1'b1;
                if (ERR_CNT == '0) begin
                    FAIL_VEC <= vec_q;
                    FAIL_GOT <= got_sum;
                end
            end
            if (last_vec) begin
                BUSY <= 1'b0;
                DONE <= 1'b1;
            end else begin
                vec_q <= vec_q + 1'b1;
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fa_vector_checker.sv
// Bench for fa_vector_checker: adder models with
// injectable faults, scoreboard of run results.
module tb_fa_vector_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start1;
    logic       start4;

    logic       a1, b1, c1, s1, co1;
    logic       busy1, done1, pass1;
    logic [3:0] err1;
    logic [2:0] fvec1;
    logic [1:0] fgot1;

    logic [3:0] a4, b4, s4;
    logic       c4, co4, busy4, done4, pass4;
    logic [9:0] err4;
    logic [8:0] fvec4;
    logic [4:0] fgot4;

    int         mode1;
    logic [1:0] sum1;
    logic [4:0] sum4;

    typedef struct {
        int err;
        int fvec;
        int fgot;
        bit pass;
        int cycles;
    } res_t;

    res_t       exp_q[$];
    logic [2:0] vec_q[$];

    int checks = 0;
    int passed = 0;

    fa_vector_checker #(.N(1), .SETTLE(2)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .START(start1),
        .A(a1), .B(b1), .C(c1), .S(s1), .CO(co1),
        .BUSY(busy1), .DONE(done1), .PASS(pass1),
        .ERR_CNT(err1), .FAIL_VEC(fvec1), .FAIL_GOT(fgot1)
    );

    fa_vector_checker #(.N(4), .SETTLE(1)) u_dut4 (
        .CLK(clk), .RST_N(rst_n), .START(start4),
        .A(a4), .B(b4), .C(c4), .S(s4), .CO(co4),
        .BUSY(busy4), .DONE(done4), .PASS(pass4),
        .ERR_CNT(err4), .FAIL_VEC(fvec4), .FAIL_GOT(fgot4)
    );

    // 1-bit full adder; mode 1 holds carry-out at 0.
    always_comb begin
        sum1 = {1'b0, a1} + {1'b0, b1} + {1'b0, c1};
        s1   = sum1[0];
        co1  = (mode1 == 1) ? 1'b0 : sum1[1];
    end

    // 4-bit adder with sum bit 0 inverted.
    always_comb begin
        sum4 = {1'b0, a4} + {1'b0, b4} + {4'b0, c4};
        s4   = sum4[3:0] ^ 4'b0001;
        co4  = sum4[4];
    end

    task automatic expect_n1(input int mode);
        res_t r;
        int   cnt = 0;
        int   fv  = 0;
        int   fg  = 0;
        for (int v = 0; v < 8; v++) begin
            int good = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
            int got  = (mode == 1) ? (good & 1) : good;
            if (got != good) begin
                if (cnt == 0) begin
                    fv = v;
                    fg = got;
                end
                cnt++;
            end
            for (int k = 0; k < 3; k++) vec_q.push_back(3'(v));
        end
        r.err    = cnt;
        r.fvec   = fv;
        r.fgot   = fg;
        r.pass   = (cnt == 0);
        r.cycles = 8 * 3;
        exp_q.push_back(r);
    endtask

    task automatic expect_n4();
        res_t r;
        int   cnt = 0;
        int   fv  = 0;
        int   fg  = 0;
        for (int v = 0; v < 512; v++) begin
            int good = ((v >> 5) & 15) + ((v >> 1) & 15) + (v & 1);
            int got  = good ^ 1;
            if (got != good) begin
                if (cnt == 0) begin
                    fv = v;
                    fg = got;
                end
                cnt++;
            end
        end
        r.err    = cnt;
        r.fvec   = fv;
        r.fgot   = fg;
        r.pass   = (cnt == 0);
        r.cycles = 512 * 2;
        exp_q.push_back(r);
    endtask

    task automatic run_n1(input string tag, input bit restart);
        res_t       e;
        int         n;
        logic [2:0] ev;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0 || err1 !== 4'd0)
            $display("FAIL %s_start busy=%b done=%b err=%0d want 1 0 0",
                     tag, busy1, done1, err1);
        else passed++;
        n = 0;
        while (busy1 === 1'b1 && n < 100) begin
            ev = 3'd0;
            if (vec_q.size() > 0) ev = vec_q.pop_front();
            checks++;
            if ({a1, b1, c1} !== ev)
                $display("FAIL %s_vec cyc=%0d got=%b want=%b",
                         tag, n, {a1, b1, c1}, ev);
            else passed++;
            n++;
            start1 = restart && (n == 5);
            @(negedge clk);
        end
        start1 = 1'b0;
        vec_q.delete();
        if (exp_q.size() == 0) begin
            $display("FAIL %s_scoreboard empty", tag);
            checks++;
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (n != e.cycles || done1 !== 1'b1)
            $display("FAIL %s_len cycles=%0d done=%b want %0d 1",
                     tag, n, done1, e.cycles);
        else passed++;
        checks++;
        if (int'(err1) != e.err)
            $display("FAIL %s_err got=%0d want=%0d", tag, err1, e.err);
        else passed++;
        checks++;
        if (int'(fvec1) != e.fvec || int'(fgot1) != e.fgot)
            $display("FAIL %s_cap vec=%b got=%b want %0d %0d",
                     tag, fvec1, fgot1, e.fvec, e.fgot);
        else passed++;
        checks++;
        if (pass1 !== e.pass)
            $display("FAIL %s_pass got=%b want=%b", tag, pass1, e.pass);
        else passed++;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({a1, b1, c1, busy1, done1, pass1, err1, fvec1, fgot1} !== '0)
            $display("FAIL reset_n1 got=%b want=0",
                     {a1, b1, c1, busy1, done1, pass1, err1, fvec1, fgot1});
        else passed++;
        checks++;
        if ({a4, b4, c4, busy4, done4, pass4, err4, fvec4, fgot4} !== '0)
            $display("FAIL reset_n4 got=%b want=0",
                     {a4, b4, c4, busy4, done4, pass4, err4, fvec4, fgot4});
        else passed++;
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || pass1 !== 1'b0)
            $display("FAIL idle_hold busy=%b done=%b pass=%b want 0 0 0",
                     busy1, done1, pass1);
        else passed++;
    endtask

    task automatic test_good_run();
        mode1 = 0;
        expect_n1(0);
        run_n1("good", 1'b0);
    endtask

    task automatic test_restart_ignored();
        mode1 = 0;
        expect_n1(0);
        run_n1("restart", 1'b1);
    endtask

    task automatic test_stuck_co();
        mode1 = 1;
        expect_n1(1);
        run_n1("stuck", 1'b0);
    endtask

    task automatic test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (done1 !== 1'b1 || err1 !== 4'd4 || busy1 !== 1'b0)
            $display("FAIL hold done=%b err=%0d busy=%b want 1 4 0",
                     done1, err1, busy1);
        else passed++;
        mode1 = 1;
        expect_n1(1);
        run_n1("b2b", 1'b0);
    endtask

    task automatic test_reset_midrun();
        int n = 0;
        mode1 = 0;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        while ({a1, b1, c1} !== 3'd4 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n >= 100) $display("FAIL midrun_reach got=%b want=100", {a1, b1, c1});
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a1, b1, c1, busy1, done1, pass1, err1, fvec1, fgot1} !== '0)
            $display("FAIL midrun_rst got=%b want=0",
                     {a1, b1, c1, busy1, done1, pass1, err1, fvec1, fgot1});
        else passed++;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({a1, b1, c1, busy1, done1} !== 5'd0)
            $display("FAIL midrun_idle got=%b want=0",
                     {a1, b1, c1, busy1, done1});
        else passed++;
        expect_n1(0);
        run_n1("after_rst", 1'b0);
    endtask

    task automatic test_wide();
        res_t e;
        int   n = 0;
        expect_n4();
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        while (busy4 === 1'b1 && n < 3000) begin
            n++;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        checks++;
        if (n != e.cycles || done4 !== 1'b1)
            $display("FAIL wide_len cycles=%0d done=%b want %0d 1",
                     n, done4, e.cycles);
        else passed++;
        checks++;
        if (int'(err4) != e.err)
            $display("FAIL wide_err got=%0d want=%0d", err4, e.err);
        else passed++;
        checks++;
        if (int'(fvec4) != e.fvec || int'(fgot4) != e.fgot)
            $display("FAIL wide_cap vec=%b got=%b want %0d %0d",
                     fvec4, fgot4, e.fvec, e.fgot);
        else passed++;
        checks++;
        if (pass4 !== e.pass)
            $display("FAIL wide_pass got=%b want=%b", pass4, e.pass);
        else passed++;
    endtask

    initial begin
        rst_n  = 1'b0;
        start1 = 1'b0;
        start4 = 1'b0;
        mode1  = 0;
        test_reset();
        test_good_run();
        test_restart_ignored();
        test_stuck_co();
        test_back_to_back();
        test_reset_midrun();
        test_wide();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
